dwpe_feeder: RTL
================

DWPE_FEEDER -- requirements
Module: dwpe_feeder

Interface
REQ-001 Parameters SHALL be: DW, 32, data word width; POX, 6, output lanes; KSIZE, 3, kernel side; NMAX, KSIZE**2, taps per window; LEN, POX+NMAX-1, pixels per row segment; TIMEOUT, 64, maximum WAIT cycles.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  request to process one segment; sampled only when ready=1.
REQ-005 pixel_in  in  LEN*DW  row segment; pixel k at bits [k*DW +: DW].
REQ-006 weight_in  in  NMAX*DW  kernel taps; tap j at bits [j*DW +: DW].
REQ-007 ready  out  1  feeder can accept start.
REQ-008 dwpe_ena  out  1  enable to the depthwise PE.
REQ-009 pixel_array  out  POX*DW  lane i pixel at bits [i*DW +: DW].
REQ-010 weight  out  DW  broadcast tap for all lanes.
REQ-011 result  in  POX*DW  PE lane results, same packing as pixel_array.
REQ-012 result_valid  in  POX  per-lane PE valid.
REQ-013 out_data  out  POX*DW  captured results, same packing.
REQ-014 out_valid  out  1  out_data is valid.
REQ-015 out_ready  in  1  downstream accepts out_data.
REQ-016 timeout_err  out  1  sticky flag: the PE failed to respond.

Function
REQ-017 The FSM SHALL have states IDLE, FEED, WAIT and OUT.
REQ-018 ready SHALL be 1 only in IDLE with result_valid all-zero; start with ready=0 SHALL be ignored.
REQ-019 On start with ready=1, the block SHALL latch pixel_in into a LEN-entry shift register, latch weight_in into an NMAX-entry tap register, clear the tap counter k, and enter FEED next cycle.
REQ-020 In FEED, outputs SHALL be dwpe_ena=1, pixel_array lane i = sreg[i], and weight = tap[k].
REQ-021 At the end of each FEED cycle, sreg SHALL shift down by one entry (sreg[n] <= sreg[n+1]) with zero filled at the top, and k SHALL increment.
REQ-022 FEED SHALL last exactly NMAX cycles, so lane i is presented pixel_in[i+j] with tap j on FEED cycle j; after cycle k=NMAX-1 the FSM SHALL enter WAIT.
REQ-023 In WAIT, dwpe_ena SHALL remain 1, pixel_array and weight SHALL be driven to all-zero, and a wait counter SHALL run from 0.
REQ-024 In WAIT, when &result_valid is 1, the block SHALL capture result into out_data, drive dwpe_ena=0 from the next cycle, and enter OUT.
REQ-025 A partial result_valid (some lanes 1, some 0) SHALL NOT cause capture.
REQ-026 If the wait counter reaches TIMEOUT without capture, the block SHALL set timeout_err=1, drop dwpe_ena, and return to IDLE without asserting out_valid.
REQ-027 In OUT, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready=1 is sampled; that cycle SHALL be the transfer, and the FSM SHALL return to IDLE next cycle.
REQ-028 Results SHALL pass through unmodified; the block SHALL perform no arithmetic on data beyond shifting.
REQ-029 timeout_err SHALL clear only on rst.
REQ-030 In IDLE and OUT, dwpe_ena SHALL be 0 and pixel_array and weight SHALL be zero.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set state=IDLE, clear sreg, tap, k, the wait counter and out_data, and set dwpe_ena=0, out_valid=0 and timeout_err=0.
REQ-032 rst asserted in any state, including mid-FEED or OUT, SHALL abort the operation with no further dwpe_ena or out_valid pulse.
REQ-033 ready SHALL be 1 on the first cycle after rst deasserts if result_valid=0.

Verification
REQ-034 Stimulus: pixel_in k = k (0..13), all taps 3, start; the bench models the PE and asserts result_valid 2 cycles after WAIT entry. Required response: 9 FEED cycles, lane i sees i+j on cycle j; out_data lane0=108, lane5=243.
REQ-035 Stimulus: taps 1..9, distinct per cycle. Required response: weight equals tap j on FEED cycle j, then 0 in WAIT.
REQ-036 Stimulus: result_valid=6'b011111 held throughout WAIT. Required response: no capture; at WAIT cycle 64, timeout_err=1 and the FSM returns to IDLE with out_valid never set.
REQ-037 Stimulus: out_ready=0 for 5 cycles in OUT, then 1. Required response: out_valid=1 and out_data stable for 6 cycles, then IDLE.
REQ-038 Stimulus: rst pulsed on FEED cycle 4. Required response: dwpe_ena=0 next cycle, all outputs zero, ready=1.
REQ-039 Stimulus: start while busy, and start while result_valid is still high in IDLE. Required response: both ignored; the next start is accepted only once result_valid=0.

Source files
------------

// File: rtl/dwpe_feeder.sv
// Feeds one row segment and a kernel's taps into a depthwise PE, one tap per cycle, then waits for all lanes and holds the results for downstream.
// Latency: start -> NMAX feed cycles -> WAIT until every lane is valid (or TIMEOUT) -> OUT until out_ready; start is refused while busy or while result_valid is still high.
module dwpe_feeder #(
    parameter int DW      = 32,
    parameter int POX     = 6,
    parameter int KSIZE   = 3,
    parameter int NMAX    = KSIZE**2,
    parameter int LEN     = POX+NMAX-1,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN*DW-1:0]   pixel_in,
    input  logic [NMAX*DW-1:0]  weight_in,
    output logic                ready,
    output logic                dwpe_ena,
    output logic [POX*DW-1:0]   pixel_array,
    output logic [DW-1:0]       weight,
    input  logic [POX*DW-1:0]   result,
    input  logic [POX-1:0]      result_valid,
    output logic [POX*DW-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                timeout_err
);

    localparam int KW = $clog2(NMAX+1);
    localparam int WW = $clog2(TIMEOUT+1);
    localparam logic [KW-1:0] K_LAST    = KW'(NMAX-1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT-1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FEED = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LEN*DW-1:0]    sreg_q, sreg_d;
    logic [NMAX*DW-1:0]   tap_q, tap_d;
    logic [KW-1:0]        k_q, k_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [POX*DW-1:0]    out_data_q, out_data_d;
    logic                 timeout_err_q, timeout_err_d;

    // A PE still asserting valid from the previous job must drain before a new one starts.
    assign ready = (state_q == S_IDLE) && (result_valid == '0);

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        tap_d         = tap_q;
        k_d           = k_q;
        wait_d        = wait_q;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (start && ready) begin
                    sreg_d  = pixel_in;
                    tap_d   = weight_in;
                    k_d     = '0;
                    wait_d  = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                sreg_d = sreg_q >> DW;
                k_d    = k_q + KW'(1);
                wait_d = '0;
                if (k_q == K_LAST) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (&result_valid) begin
                    out_data_d = result;
                    state_d    = S_OUT;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sreg_q        <= '0;
            tap_q         <= '0;
            k_q           <= '0;
            wait_q        <= '0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            tap_q         <= tap_d;
            k_q           <= k_d;
            wait_q        <= wait_d;
            out_data_q    <= out_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign dwpe_ena    = (state_q == S_FEED) || (state_q == S_WAIT);
    assign pixel_array = (state_q == S_FEED) ? sreg_q[POX*DW-1:0] : '0;
    assign weight      = (state_q == S_FEED) ? tap_q[k_q*DW +: DW] : '0;
    assign out_valid   = (state_q == S_OUT);
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;

endmodule
